// File: rtl/fd_pipe_reg_if.sv
// Fetch-to-decode bundle: F-stage inputs and control come in, the latched D-stage view goes out.
// The master modport is the upstream side that drives F and control; the slave modport is the register.
interface fd_pipe_reg_if;
    logic        block;
    logic        Req;
    logic        D_eret;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_BD;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_BD;
    logic        D_Exc;
    logic [4:0]  D_ExcCode;
    logic        D_valid;

    modport master (
        output block, Req, D_eret, F_PC, F_Instr, F_BD,
        input  D_PC, D_Instr, D_BD, D_Exc, D_ExcCode, D_valid
    );

    modport slave (
        input  block, Req, D_eret, F_PC, F_Instr, F_BD,
        output D_PC, D_Instr, D_BD, D_Exc, D_ExcCode, D_valid
    );
endinterface

// File: rtl/fd_pipe_reg.sv
// F->D pipeline register of the MIPS core. It checks the fetch address (AdEL), tags delay slots,
// holds on stall, and inserts bubbles on exception entry and on eret.
module fd_pipe_reg #(
    parameter logic [31:0] INIT_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6ffc,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic          clk,
    input  logic          reset,
    fd_pipe_reg_if.slave  bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        bd_q, bd_d;
    logic        exc_q, exc_d;
    logic [4:0]  exc_code_q, exc_code_d;
    logic        valid_q, valid_d;
    logic        fault;

    assign fault = (bus.F_PC[1:0] != 2'b00) | (bus.F_PC < IM_LO) | (bus.F_PC > IM_HI);

    // Flush beats stall; stall beats the eret squash, so a stalled eret squashes on the first free edge.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        bd_d       = bd_q;
        exc_d      = exc_q;
        exc_code_d = exc_code_q;
        valid_d    = valid_q;
        if (bus.Req) begin
            pc_d       = EXC_PC;
            instr_d    = 32'h0;
            bd_d       = 1'b0;
            exc_d      = 1'b0;
            exc_code_d = 5'd0;
            valid_d    = 1'b0;
        end else if (bus.block) begin
            pc_d = pc_q;
        end else if (bus.D_eret) begin
            pc_d       = bus.F_PC;
            instr_d    = 32'h0;
            bd_d       = 1'b0;
            exc_d      = 1'b0;
            exc_code_d = 5'd0;
            valid_d    = 1'b0;
        end else begin
            // A faulting PC is kept verbatim so CP0 can record it as EPC/BadVAddr.
            pc_d       = bus.F_PC;
            bd_d       = bus.F_BD;
            valid_d    = 1'b1;
            instr_d    = fault ? 32'h0 : bus.F_Instr;
            exc_d      = fault;
            exc_code_d = fault ? EXC_ADEL : 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= INIT_PC;
            instr_q    <= 32'h0;
            bd_q       <= 1'b0;
            exc_q      <= 1'b0;
            exc_code_q <= 5'd0;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            bd_q       <= bd_d;
            exc_q      <= exc_d;
            exc_code_q <= exc_code_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.D_PC      = pc_q;
    assign bus.D_Instr   = instr_q;
    assign bus.D_BD      = bd_q;
    assign bus.D_Exc     = exc_q;
    assign bus.D_ExcCode = exc_code_q;
    assign bus.D_valid   = valid_q;

endmodule
